// File: rtl/cpu_run_sequencer.sv
// Hardware launcher for the CPU Reset/Start/Ack protocol: parks the CPU in reset,
// preloads two operands, starts it, waits for Ack and checks the result word.
module cpu_run_sequencer #(
  parameter int DW          = 8,
  parameter int AW          = 8,
  parameter int CW          = 16,
  parameter int RST_CYC     = 2,
  parameter int START_CYC   = 2,
  parameter int TIMEOUT_CYC = 4096,
  parameter int OPA_ADDR    = 1,
  parameter int OPB_ADDR    = 2,
  parameter int RES_ADDR    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  input  logic [DW-1:0] exp_result,
  output logic          dut_reset,
  output logic          dut_start,
  input  logic          dut_ack,
  output logic          mem_host_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr_data,
  output logic          mem_wr_en,
  input  logic [DW-1:0] mem_rd_data,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timed_out,
  output logic [DW-1:0] result,
  output logic [CW-1:0] wait_cycles
);

  typedef enum logic [2:0] {IDLE, RST, LOAD_A, LOAD_B, HOLD, WAIT, READ, REPORT} state_t;

  state_t        state;
  state_t        next_state;
  logic [7:0]    cnt;
  logic [DW-1:0] op_a_q;
  logic [DW-1:0] op_b_q;
  logic [DW-1:0] exp_q;
  logic          timeout_hit;

  assign timeout_hit = (wait_cycles == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (go) next_state = RST;
      RST:     if (cnt == 8'(RST_CYC - 1)) next_state = LOAD_A;
      LOAD_A:  next_state = LOAD_B;
      LOAD_B:  next_state = HOLD;
      HOLD:    if (cnt == 8'(START_CYC - 1)) next_state = WAIT;
      // Ack beats a simultaneous timeout.
      WAIT: begin
        if (dut_ack)          next_state = READ;
        else if (timeout_hit) next_state = REPORT;
      end
      READ:    next_state = REPORT;
      REPORT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next_state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      exp_q       <= '0;
      dut_reset   <= 1'b1;
      dut_start   <= 1'b0;
      mem_host_en <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      mem_wr_en   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timed_out   <= 1'b0;
      result      <= '0;
      wait_cycles <= '0;
    end else begin
      state       <= next_state;
      cnt         <= (next_state == state) ? cnt + 8'd1 : 8'd0;
      busy        <= (next_state != IDLE);
      done        <= (next_state == REPORT);
      dut_reset   <= (next_state == IDLE) || (next_state == RST);
      dut_start   <= (next_state == RST) || (next_state == LOAD_A) ||
                     (next_state == LOAD_B) || (next_state == HOLD);
      mem_host_en <= (next_state == LOAD_A) || (next_state == LOAD_B) || (next_state == READ);
      mem_wr_en   <= (next_state == LOAD_A) || (next_state == LOAD_B);

      if (next_state == LOAD_A) begin
        mem_addr    <= AW'(OPA_ADDR);
        mem_wr_data <= op_a_q;
      end else if (next_state == LOAD_B) begin
        mem_addr    <= AW'(OPB_ADDR);
        mem_wr_data <= op_b_q;
      end else if (next_state == READ) begin
        mem_addr    <= AW'(RES_ADDR);
        mem_wr_data <= '0;
      end else begin
        mem_addr    <= '0;
        mem_wr_data <= '0;
      end

      case (state)
        IDLE: begin
          if (go) begin
            op_a_q      <= op_a;
            op_b_q      <= op_b;
            exp_q       <= exp_result;
            pass        <= 1'b0;
            timed_out   <= 1'b0;
            result      <= '0;
            wait_cycles <= '0;
          end
        end
        WAIT: begin
          if (!dut_ack) begin
            if (timeout_hit) begin
              timed_out   <= 1'b1;
              wait_cycles <= wait_cycles + CW'(1);
            end else if (wait_cycles != '1) begin
              wait_cycles <= wait_cycles + CW'(1);
            end
          end
        end
        // Only reachable without a timeout, so Pass depends on the compare alone.
        READ: begin
          result <= mem_rd_data;
          pass   <= (mem_rd_data == exp_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Directed bench for cpu_run_sequencer with a small data memory and a scripted CPU model.
module tb_cpu_run_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic [7:0]  op_a, op_b, exp_result;
  logic        dut_reset, dut_start, dut_ack;
  logic        mem_host_en, mem_wr_en;
  logic [7:0]  mem_addr, mem_wr_data, mem_rd_data;
  logic        busy, done, pass, timed_out;
  logic [7:0]  result;
  logic [15:0] wait_cycles;

  logic [7:0]  mem [256];
  logic        cpu_we;
  logic [7:0]  cpu_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_run_sequencer #(
    .DW(8), .AW(8), .CW(16), .RST_CYC(2), .START_CYC(2), .TIMEOUT_CYC(64),
    .OPA_ADDR(1), .OPB_ADDR(2), .RES_ADDR(3)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .op_a(op_a), .op_b(op_b), .exp_result(exp_result),
    .dut_reset(dut_reset), .dut_start(dut_start), .dut_ack(dut_ack),
    .mem_host_en(mem_host_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_en(mem_wr_en), .mem_rd_data(mem_rd_data), .busy(busy), .done(done),
    .pass(pass), .timed_out(timed_out), .result(result), .wait_cycles(wait_cycles)
  );

  // Shared data memory: sequencer port when it owns the bus, CPU model writes the result word.
  always @(posedge clk) begin
    if (mem_host_en && mem_wr_en) mem[mem_addr] <= mem_wr_data;
    if (cpu_we) mem[3] <= cpu_wdata;
  end
  assign mem_rd_data = mem[mem_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Go pulse through RST/LOAD/HOLD; returns on the first WAIT cycle.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic [7:0] e,
                        input logic hold_ack);
    op_a = a; op_b = b; exp_result = e; go = 1'b1;
    step();
    go = 1'b0;
    check("rst_phase", {29'd0, dut_reset, dut_start, busy}, 32'b111);
    step();
    check("rst_phase2", {30'd0, dut_reset, dut_start}, 32'b11);
    step();
    check("load_a_ctl", {28'd0, mem_host_en, mem_wr_en, dut_reset, dut_start}, 32'b1101);
    check("load_a_addr", {24'd0, mem_addr}, 32'd1);
    check("load_a_data", {24'd0, mem_wr_data}, {24'd0, a});
    step();
    check("load_b_addr", {24'd0, mem_addr}, 32'd2);
    check("load_b_data", {24'd0, mem_wr_data}, {24'd0, b});
    step();
    check("hold_ctl", {28'd0, mem_host_en, mem_wr_en, dut_reset, dut_start}, 32'b0001);
    check("mem_opa", {24'd0, mem[1]}, {24'd0, a});
    check("mem_opb", {24'd0, mem[2]}, {24'd0, b});
    dut_ack = hold_ack;
    step();
    step();
    dut_ack = 1'b0;
    check("wait_entry", {29'd0, dut_start, mem_host_en, busy}, 32'b001);
    check("wait_start_cnt", {16'd0, wait_cycles}, 32'd0);
  endtask

  // CPU model finishes: writes the result word and pulses Ack; returns in REPORT.
  task automatic cpu_ack(input logic [7:0] val);
    cpu_we = 1'b1; cpu_wdata = val; dut_ack = 1'b1;
    step();
    cpu_we = 1'b0; dut_ack = 1'b0;
    check("read_ctl", {30'd0, mem_host_en, mem_wr_en}, 32'b10);
    check("read_addr", {24'd0, mem_addr}, 32'd3);
    step();
  endtask

  task automatic expect_report(input logic p, input logic t, input logic [7:0] r,
                               input logic [15:0] wc);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("pass", {31'd0, pass}, {31'd0, p});
    check("timed_out", {31'd0, timed_out}, {31'd0, t});
    check("result", {24'd0, result}, {24'd0, r});
    check("wait_cycles", {16'd0, wait_cycles}, {16'd0, wc});
    step();
    check("idle_after", {29'd0, done, busy, dut_reset}, 32'b001);
    check("pass_held", {31'd0, pass}, {31'd0, p});
    check("result_held", {24'd0, result}, {24'd0, r});
  endtask

  initial begin
    int done_count;
    reset = 1'b1; go = 1'b0; op_a = '0; op_b = '0; exp_result = '0;
    dut_ack = 1'b0; cpu_we = 1'b0; cpu_wdata = '0;
    step();
    step();
    check("reset_ctl", {27'd0, dut_reset, dut_start, busy, done, mem_host_en}, 32'b10000);
    check("reset_stat", {29'd0, pass, timed_out, mem_wr_en}, 32'd0);
    check("reset_wc", {16'd0, wait_cycles}, 32'd0);
    reset = 1'b0;
    step();

    $display("[TB] test 1: matching result, ack at WaitCycles=30");
    launch(8'h0B, 8'h04, 8'h07, 1'b0);
    repeat (30) step();
    check("wc_before_ack", {16'd0, wait_cycles}, 32'd30);
    cpu_ack(8'h07);
    expect_report(1'b1, 1'b0, 8'h07, 16'd30);

    $display("[TB] test 2: wrong result, Go held during REPORT");
    launch(8'h0B, 8'h04, 8'h07, 1'b0);
    repeat (30) step();
    cpu_ack(8'h08);
    go = 1'b1;
    check("done_pulse2", {31'd0, done}, 32'd1);
    check("pass2", {31'd0, pass}, 32'd0);
    check("timed_out2", {31'd0, timed_out}, 32'd0);
    check("result2", {24'd0, result}, 32'h08);
    step();
    go = 1'b0;
    check("go_in_report_ignored", {30'd0, busy, dut_reset}, 32'b01);
    step();
    check("still_idle", {31'd0, busy}, 32'd0);

    $display("[TB] test 3: no ack, timeout after 64 WAIT cycles");
    launch(8'h01, 8'h02, 8'h00, 1'b0);
    repeat (63) step();
    check("no_early_timeout", {30'd0, done, busy}, 32'b01);
    step();
    expect_report(1'b0, 1'b1, 8'h00, 16'd64);

    $display("[TB] test 3b: ack on the last WAIT cycle beats timeout");
    launch(8'h10, 8'h20, 8'h30, 1'b0);
    repeat (63) step();
    cpu_ack(8'h30);
    expect_report(1'b1, 1'b0, 8'h30, 16'd63);

    $display("[TB] test 4: ack during HOLD is ignored");
    launch(8'h22, 8'h33, 8'h44, 1'b1);
    check("hold_ack_ignored", {30'd0, mem_host_en, done}, 32'd0);
    repeat (64) step();
    expect_report(1'b0, 1'b1, 8'h00, 16'd64);

    $display("[TB] test 5: Go re-pulsed during WAIT");
    launch(8'h05, 8'h03, 8'h02, 1'b0);
    repeat (10) step();
    op_a = 8'hFF; op_b = 8'hEE; exp_result = 8'h55; go = 1'b1;
    step();
    go = 1'b0;
    check("no_restart", {29'd0, dut_reset, dut_start, busy}, 32'b001);
    check("wc_continues", {16'd0, wait_cycles}, 32'd11);
    repeat (9) step();
    cpu_ack(8'h02);
    check("mem_opa_kept", {24'd0, mem[1]}, 32'h05);
    expect_report(1'b1, 1'b0, 8'h02, 16'd20);
    done_count = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) done_count++;
      step();
    end
    check("single_done", done_count, 32'd0);

    $display("[TB] test 6: reset mid-WAIT, then a clean run");
    launch(8'h09, 8'h01, 8'h08, 1'b0);
    repeat (5) step();
    reset = 1'b1;
    step();
    check("reset_mid_ctl", {28'd0, dut_reset, dut_start, busy, done}, 32'b1000);
    check("reset_mid_wc", {16'd0, wait_cycles}, 32'd0);
    reset = 1'b0;
    done_count = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) done_count++;
      step();
    end
    check("no_done_after_reset", done_count, 32'd0);
    launch(8'h09, 8'h01, 8'h08, 1'b0);
    repeat (3) step();
    cpu_ack(8'h08);
    expect_report(1'b1, 1'b0, 8'h08, 16'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
